csr_unit: RTL

- Parametrised machine-mode CSR block that succeeds the flat CSR register array with a decoded, bounded CSR set.
- Performs atomic CSR read-modify-write operations (RW/RS/RC), runs 64-bit cycle and instret counters, and handles trap entry and MRET state updates.
- Sits beside the register file in the EX/WB stage.
- Reads are asynchronous (old value); all state updates occur on the rising clock edge.

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_counter.sv | 46 ++++
 rtl/csr_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: addresses, op encoding,
// mstatus bit positions and default widths.
package csr_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int NUM_SCRATCH_DEF = 1;
    localparam int CNT_W_DEF       = 64;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    // Extra scratch registers sit contiguously from here upwards.
    localparam int CSR_SCRATCH_EXT = 32'h0000_0343;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    function automatic logic is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running counter with independently writable 32-bit low/high halves;
// a write to either half takes priority over the increment.
module csr_counter
    import csr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] value
);

    localparam logic [CNT_W-1:0] LO_MASK = CNT_W'(64'h0000_0000_FFFF_FFFF);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] next_s;

    // Next count: half replacement beats the increment for the whole counter.
    always_comb begin
        if (wr_lo) begin
            next_s = (cnt_r & ~LO_MASK) | CNT_W'({32'h0000_0000, wdata});
        end else if (wr_hi) begin
            next_s = (cnt_r & LO_MASK) | CNT_W'({wdata, 32'h0000_0000});
        end else if (inc) begin
            next_s = cnt_r + CNT_W'(1'b1);
        end else begin
            next_s = cnt_r;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= next_s;
        end
    end

    assign value = cnt_r;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR block: atomic RW/RS/RC access, 64-bit cycle/instret
// counters, trap entry and MRET. Build option CSR_VECTORED_EN enables mtvec MODE.
module csr_unit
    import csr_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int NUM_SCRATCH = NUM_SCRATCH_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_src,
    input  logic            csr_src_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic            mret,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] epc,
    output logic            irq_en
);

    csr_op_e                op_s;
    logic                   mie_r, mpie_r;
    logic [XLEN-1:0]        mtvec_r, mepc_r, mcause_r;
    logic [XLEN-1:0]        scratch_r [NUM_SCRATCH];
    logic [NUM_SCRATCH-1:0] scr_sel_s;
    logic [XLEN-1:0]        mstatus_s, old_s, new_s, mtvec_wr_s, base_s;
    logic                   hit_s, wants_wr_s, illegal_s, wr_s;
    logic [CNT_W-1:0]       cycle_s, instret_s;
    logic [63:0]            cyc64_s, ins64_s;

    assign op_s    = csr_op_e'(csr_op);
    assign cyc64_s = 64'(cycle_s);
    assign ins64_s = 64'(instret_s);

    // Scratch register address decode.
    always_comb begin
        scr_sel_s    = {NUM_SCRATCH{1'b0}};
        scr_sel_s[0] = (csr_addr == CSR_MSCRATCH);
        for (int i = 1; i < NUM_SCRATCH; i++) begin
            scr_sel_s[i] = (csr_addr == 12'(CSR_SCRATCH_EXT + i - 1));
        end
    end

    // Read mux over the decoded CSR set; mstatus exposes only MIE/MPIE.
    always_comb begin
        mstatus_s               = {XLEN{1'b0}};
        mstatus_s[MSTATUS_MIE]  = mie_r;
        mstatus_s[MSTATUS_MPIE] = mpie_r;
        old_s = {XLEN{1'b0}};
        hit_s = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:               old_s = mstatus_s;
            CSR_MTVEC:                 old_s = mtvec_r;
            CSR_MEPC:                  old_s = mepc_r;
            CSR_MCAUSE:                old_s = mcause_r;
            CSR_MCYCLE,   CSR_CYCLE:   old_s = XLEN'(cyc64_s[31:0]);
            CSR_MCYCLEH,  CSR_CYCLEH:  old_s = XLEN'(cyc64_s[63:32]);
            CSR_MINSTRET, CSR_INSTRET: old_s = XLEN'(ins64_s[31:0]);
            CSR_MINSTRETH, CSR_INSTRETH: old_s = XLEN'(ins64_s[63:32]);
            default: begin
                hit_s = |scr_sel_s;
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    old_s = old_s | (scr_sel_s[i] ? scratch_r[i] : {XLEN{1'b0}});
                end
            end
        endcase
    end

    // Read-modify-write value, legality and write strobe.
    always_comb begin
        case (op_s)
            CSR_RW:  new_s = csr_src;
            CSR_RS:  new_s = old_s | csr_src;
            CSR_RC:  new_s = old_s & ~csr_src;
            default: new_s = old_s;
        endcase
        wants_wr_s = (op_s == CSR_RW) || ((op_s != CSR_NONE) && !csr_src_zero);
        illegal_s  = (op_s != CSR_NONE) &&
                     (!hit_s || (is_read_only(csr_addr) && wants_wr_s));
        wr_s       = wants_wr_s && !illegal_s;
    end

    // mtvec write filtering and trap redirect target.
    always_comb begin
        base_s = {mtvec_r[XLEN-1:2], 2'b00};
`ifdef CSR_VECTORED_EN
        mtvec_wr_s = {new_s[XLEN-1:2], (new_s[1:0] == 2'b01) ? 2'b01 : 2'b00};
        if ((mtvec_r[1:0] == 2'b01) && trap_cause[XLEN-1]) begin
            trap_vector = base_s + XLEN'({trap_cause[5:0], 2'b00});
        end else begin
            trap_vector = base_s;
        end
`else
        mtvec_wr_s  = {new_s[XLEN-1:2], 2'b00};
        trap_vector = base_s;
`endif
    end

    // Architectural state: trap beats MRET beats CSR writes for mstatus/mepc/mcause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_r    <= 1'b0;
            mpie_r   <= 1'b0;
            mtvec_r  <= {XLEN{1'b0}};
            mepc_r   <= {XLEN{1'b0}};
            mcause_r <= {XLEN{1'b0}};
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (trap_valid) begin
                mepc_r   <= {trap_pc[XLEN-1:2], 2'b00};
                mcause_r <= trap_cause;
                mpie_r   <= mie_r;
                mie_r    <= 1'b0;
            end else if (mret) begin
                mie_r    <= mpie_r;
                mpie_r   <= 1'b1;
            end else if (wr_s) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie_r  <= new_s[MSTATUS_MIE];
                        mpie_r <= new_s[MSTATUS_MPIE];
                    end
                    CSR_MEPC:   mepc_r   <= {new_s[XLEN-1:2], 2'b00};
                    CSR_MCAUSE: mcause_r <= new_s;
                    default:    mcause_r <= mcause_r;
                endcase
            end
            if (wr_s && (csr_addr == CSR_MTVEC)) begin
                mtvec_r <= mtvec_wr_s;
            end
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_s && scr_sel_s[i]) begin
                    scratch_r[i] <= new_s;
                end
            end
        end
    end

    csr_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (wr_s && (csr_addr == CSR_MCYCLE)),
        .wr_hi (wr_s && (csr_addr == CSR_MCYCLEH)),
        .wdata (new_s[31:0]),
        .value (cycle_s)
    );

    csr_counter #(.CNT_W(CNT_W)) u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .wr_lo (wr_s && (csr_addr == CSR_MINSTRET)),
        .wr_hi (wr_s && (csr_addr == CSR_MINSTRETH)),
        .wdata (new_s[31:0]),
        .value (instret_s)
    );

    assign csr_rdata   = ((op_s != CSR_NONE) && hit_s) ? old_s : {XLEN{1'b0}};
    assign csr_illegal = illegal_s;
    assign epc         = mepc_r;
    assign irq_en      = mie_r;

endmodule
